// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_pkg;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 16;
  localparam int REG_ADDR_W = 3;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

endpackage

// File: rtl/var_reg.sv
// Parameterised pipeline register with synchronous reset, clear (bubble) and hold enable.
module var_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= {W{1'b0}};
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: data-memory req/ready access with upstream stall and MEM/WB register.
// Optional abort on long memory waits is enabled by defining MEM_TIMEOUT_EN.
module memory_stage
  import mem_pkg::*;
#(
  parameter int DATA_W         = mem_pkg::DATA_W,
  parameter int ADDR_W         = mem_pkg::ADDR_W,
  parameter int REG_ADDR_W     = mem_pkg::REG_ADDR_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     alu_result_from_ex,
  input  logic                  RegWrite_from_ex,
  input  logic [REG_ADDR_W-1:0] reg_write_address_from_ex,
  input  logic [DATA_W-1:0]     sign_extend_from_ex,
  input  logic                  write_back_select_from_ex,
  input  logic [DATA_W-1:0]     reg_file_read_data2_from_ex,
  input  logic                  memRead_from_ex,
  input  logic                  memWrite_from_ex,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic [DATA_W-1:0]     dmem_rdata,
  input  logic                  dmem_ready,
  output logic                  mem_stall,
  output logic                  RegWrite_to_wb,
  output logic [REG_ADDR_W-1:0] reg_write_address_to_wb,
  output logic [DATA_W-1:0]     write_back_data_to_wb,
  output logic [DATA_W-1:0]     sign_extend_to_wb,
  output logic                  mem_error
);

  localparam int PAY_W = REG_ADDR_W + 2 * DATA_W;

  mem_state_e        state;
  logic [DATA_W-1:0] wait_cnt;
  logic              mem_op;
  logic              timeout_hit;
  logic              bubble;
  logic [DATA_W-1:0] wb_data;

  assign mem_op     = memRead_from_ex | memWrite_from_ex;
  assign dmem_req   = mem_op & ~reset;
  assign dmem_we    = memWrite_from_ex;
  assign dmem_addr  = ADDR_W'(alu_result_from_ex);
  assign dmem_wdata = reg_file_read_data2_from_ex;

`ifdef MEM_TIMEOUT_EN
  assign timeout_hit = (state == MEM_WAIT) && (wait_cnt >= DATA_W'(TIMEOUT_CYCLES));

  // Sticky abort flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_error <= 1'b0;
    end else if (timeout_hit) begin
      mem_error <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_hit        = 1'b0;
  assign mem_error          = 1'b0;
`endif

  assign mem_stall = mem_op & ~dmem_ready & ~timeout_hit;
  assign bubble    = mem_stall | timeout_hit;

  // Access FSM and per-access saturating wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MEM_IDLE;
      wait_cnt <= {DATA_W{1'b0}};
    end else begin
      case (state)
        MEM_IDLE: begin
          wait_cnt <= {DATA_W{1'b0}};
          if (mem_op && !dmem_ready) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (dmem_ready || timeout_hit) begin
            state    <= MEM_IDLE;
            wait_cnt <= {DATA_W{1'b0}};
          end else if (wait_cnt != {DATA_W{1'b1}}) begin
            wait_cnt <= wait_cnt + {{(DATA_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state    <= MEM_IDLE;
          wait_cnt <= {DATA_W{1'b0}};
        end
      endcase
    end
  end

  // A load with the write flag also set is a store, so its load data reads as zero.
  always_comb begin
    wb_data = alu_result_from_ex;
    case (write_back_select_from_ex)
      WB_SEL_ALU: wb_data = alu_result_from_ex;
      WB_SEL_MEM: wb_data = (memRead_from_ex && !memWrite_from_ex) ? dmem_rdata : {DATA_W{1'b0}};
      default:    wb_data = alu_result_from_ex;
    endcase
  end

  var_reg #(.W(PAY_W)) u_wb_payload (
    .clk   (clk),
    .reset (reset),
    .en    (~bubble),
    .clr   (1'b0),
    .d     ({reg_write_address_from_ex, wb_data, sign_extend_from_ex}),
    .q     ({reg_write_address_to_wb, write_back_data_to_wb, sign_extend_to_wb})
  );

  var_reg #(.W(1)) u_wb_regwrite (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (bubble),
    .d     (RegWrite_from_ex),
    .q     (RegWrite_to_wb)
  );

endmodule
